// File: rtl/fft_pkg.sv
// Shared FFT definitions: loader FSM states, twiddle-table sizing and
// the radix-2 DIT exponent schedule used to address the twiddle ROM.
package fft_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Number of butterflies per stage (and ROM entries): 2^(npoint-1).
  function automatic int fft_half(input int npoint);
    return 1 << (npoint - 1);
  endfunction

  // Total twiddle pushes for a full transform: npoint stages of HALF each.
  function automatic int fft_total(input int npoint);
    return npoint * fft_half(npoint);
  endfunction

  // Fractional bits of the Q2.(width-2) twiddle format, so +1.0 fits.
  function automatic int q_shift(input int width);
    return width - 2;
  endfunction

  // Exponent k for push index p: stage s = p / HALF, butterfly b = p mod HALF,
  // k = (b mod 2^s) * 2^(npoint-1-s).
  function automatic int twiddle_exp(input int p, input int npoint);
    int half;
    int s;
    int b;
    half = fft_half(npoint);
    s    = p / half;
    b    = p % half;
    return (b % (1 << s)) * (1 << (npoint - 1 - s));
  endfunction

endpackage

// File: rtl/twiddle_loader_if.sv
// Streaming bus between the twiddle loader and its consumer: a one-cycle
// start request, status flags and the qualified complex weight.
interface twiddle_loader_if #(
  parameter int WIDTH = 16
);

  logic                    start;
  logic                    busy;
  logic                    done;
  logic                    dout_weight_valid;
  logic signed [WIDTH-1:0] dout_weight_real;
  logic signed [WIDTH-1:0] dout_weight_imag;

  // The loader produces the stream.
  modport master (
    input  start,
    output busy,
    output done,
    output dout_weight_valid,
    output dout_weight_real,
    output dout_weight_imag
  );

  // The consumer requests a stream and accepts every valid beat.
  modport slave (
    output start,
    input  busy,
    input  done,
    input  dout_weight_valid,
    input  dout_weight_real,
    input  dout_weight_imag
  );

endinterface

// File: rtl/twiddle_rom.sv
// Twiddle factor ROM: HALF entries of W^k = cos(2*pi*k/N) - j*sin(2*pi*k/N)
// in Q2.(WIDTH-2), read synchronously; the read register holds when idle.
module twiddle_rom
  import fft_pkg::*;
#(
  parameter int NPOINT = 3,
  parameter int WIDTH  = 16,
  parameter int ADDR_W = (NPOINT > 1) ? NPOINT - 1 : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [ADDR_W-1:0]       addr,
  output logic signed [WIDTH-1:0] rd_real,
  output logic signed [WIDTH-1:0] rd_imag
);

  localparam int  HALF = fft_half(NPOINT);
  localparam int  Q    = q_shift(WIDTH);
  localparam real PI   = 3.14159265358979323846;

  // Scale a real value into Q format, rounding half away from zero.
  function automatic logic signed [WIDTH-1:0] to_q(input real x);
    real    scaled;
    integer v;
    scaled = x * (2.0 ** Q);
    if (scaled >= 0.0) v = $rtoi(scaled + 0.5);
    else               v = $rtoi(scaled - 0.5);
    return WIDTH'(v);
  endfunction

  generate
    if (NPOINT == 1) begin : g_const
      // A 2-point FFT only ever needs W^0, so no table or address is used.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd_real <= '0;
          rd_imag <= '0;
        end else if (en) begin
          rd_real <= to_q(1.0);
          rd_imag <= '0;
        end
      end
    end else begin : g_table
      logic signed [WIDTH-1:0] rom_re [HALF];
      logic signed [WIDTH-1:0] rom_im [HALF];

      for (genvar i = 0; i < HALF; i++) begin : g_entry
        assign rom_re[i] = to_q($cos(2.0 * PI * real'(i) / real'(1 << NPOINT)));
        assign rom_im[i] = to_q(-$sin(2.0 * PI * real'(i) / real'(1 << NPOINT)));
      end

      // Registered read; the output holds its last value while disabled.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd_real <= '0;
          rd_imag <= '0;
        end else if (en) begin
          rd_real <= rom_re[addr];
          rd_imag <= rom_im[addr];
        end
      end
    end
  endgenerate

endmodule

// File: rtl/twiddle_loader.sv
// Twiddle loader: on start, streams the full set of radix-2 DIT twiddle
// factors (NPOINT stages x HALF butterflies) in push order, one per cycle.
module twiddle_loader
  import fft_pkg::*;
#(
  parameter int NPOINT = 3,
  parameter int WIDTH  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  twiddle_loader_if.master  bus
);

  localparam int TOTAL  = fft_total(NPOINT);
  localparam int ADDR_W = (NPOINT > 1) ? NPOINT - 1 : 1;
  localparam int P_W    = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam logic [P_W-1:0] P_LAST = P_W'(TOTAL - 1);

  state_t                  state;
  state_t                  next_state;
  logic [P_W-1:0]          p;
  logic [P_W-1:0]          next_p;
  logic                    valid_q;
  logic                    done_q;
  logic                    rom_en;
  logic [ADDR_W-1:0]       rom_addr;
  logic signed [WIDTH-1:0] w_re;
  logic signed [WIDTH-1:0] w_im;

  // State, push counter, and the valid/done flags aligned with the ROM read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      p       <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= next_state;
      p       <= next_p;
      valid_q <= (state == LOAD);
      done_q  <= (state == DRAIN);
    end
  end

  // Next state, counter advance and ROM address for the current push.
  always_comb begin
    next_state = state;
    next_p     = p;
    rom_en     = 1'b0;
    rom_addr   = '0;
    case (state)
      IDLE: begin
        if (bus.start && !done_q) begin
          next_state = LOAD;
          next_p     = '0;
        end
      end
      LOAD: begin
        rom_en   = 1'b1;
        rom_addr = ADDR_W'(twiddle_exp(int'(p), NPOINT));
        if (p == P_LAST) begin
          next_state = DRAIN;
          next_p     = '0;
        end else begin
          next_p = p + 1'b1;
        end
      end
      DRAIN: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  twiddle_rom #(
    .NPOINT (NPOINT),
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W)
  ) u_rom (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (rom_en),
    .addr    (rom_addr),
    .rd_real (w_re),
    .rd_imag (w_im)
  );

  assign bus.busy              = (state != IDLE);
  assign bus.done              = done_q;
  assign bus.dout_weight_valid = valid_q;
  assign bus.dout_weight_real  = w_re;
  assign bus.dout_weight_imag  = w_im;

endmodule

// File: tb/tb_twiddle_loader.sv
// Self-checking bench for twiddle_loader: an 8-point/16-bit instance checked
// against a scoreboard of expected weights, plus a 16-point/12-bit instance.
module tb_twiddle_loader;

  typedef struct packed {
    logic signed [15:0] re;
    logic signed [15:0] im;
  } w16_t;

  typedef struct packed {
    logic signed [11:0] re;
    logic signed [11:0] im;
  } w12_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  int vectors     = 0;
  int miscompares = 0;

  w16_t exp_q[$];
  w16_t obs_q[$];
  w16_t sbuf[12];
  w16_t wtab[4];
  int   kseq[12];
  w12_t obs4[32];

  always #5 clk = ~clk;

  twiddle_loader_if #(.WIDTH(16)) bus3 ();
  twiddle_loader_if #(.WIDTH(12)) bus4 ();

  twiddle_loader #(.NPOINT(3), .WIDTH(16)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3.master)
  );

  twiddle_loader #(.NPOINT(4), .WIDTH(12)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4.master)
  );

  task automatic push_stream3();
    for (int i = 0; i < 12; i++) exp_q.push_back(wtab[kseq[i]]);
  endtask

  task automatic pulse_start3();
    bus3.start = 1'b1;
    @(negedge clk);
    bus3.start = 1'b0;
  endtask

  // Collects beats from the 8-point instance until its done pulse.
  // mode 1 keeps start asserted whenever busy or done is high.
  task automatic capture3(input int budget, input int mode, output int beats,
                          output int dones, output int first_v, output int last_v,
                          output logic busy_at_done, output bit timed_out);
    w16_t w;
    beats = 0; dones = 0; first_v = -1; last_v = -1;
    busy_at_done = 1'b1; timed_out = 1'b1;
    for (int c = 0; c < budget; c++) begin
      if (bus3.dout_weight_valid === 1'b1) begin
        w.re = bus3.dout_weight_real;
        w.im = bus3.dout_weight_imag;
        obs_q.push_back(w);
        for (int i = 11; i > 0; i--) sbuf[i] = sbuf[i-1];
        sbuf[0] = w;
        beats++;
        if (first_v < 0) first_v = c;
        last_v = c;
      end
      if (bus3.done === 1'b1) begin
        dones++;
        busy_at_done = bus3.busy;
      end
      if (mode == 1) bus3.start = bus3.busy | bus3.done;
      else           bus3.start = 1'b0;
      if (dones > 0) begin
        timed_out = 1'b0;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++; if (bus3.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b expected 0", bus3.busy); end
    vectors++; if (bus3.done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done: got %b expected 0", bus3.done); end
    vectors++; if (bus3.dout_weight_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_valid: got %b expected 0", bus3.dout_weight_valid); end
    vectors++; if (bus3.dout_weight_real !== 16'sd0 || bus3.dout_weight_imag !== 16'sd0) begin
      miscompares++; $display("[TB] FAIL reset_weight: got (%0d,%0d) expected (0,0)", bus3.dout_weight_real, bus3.dout_weight_imag);
    end
    rst_n = 1'b1;
    @(negedge clk);
    vectors++; if (bus3.busy !== 1'b0 || bus4.busy !== 1'b0) begin
      miscompares++; $display("[TB] FAIL idle_after_reset: got busy %b/%b expected 0/0", bus3.busy, bus4.busy);
    end
  endtask

  task automatic test_single_stream();
    int beats, dones, fv, lv, n;
    logic bad;
    bit to;
    w16_t e, o;
    obs_q.delete();
    push_stream3();
    pulse_start3();
    capture3(40, 0, beats, dones, fv, lv, bad, to);
    vectors++; if (to) begin miscompares++; $display("[TB] FAIL single_timeout: got no done expected done within 40 cycles"); end
    vectors++; if (beats != 12) begin miscompares++; $display("[TB] FAIL single_beats: got %0d expected 12", beats); end
    vectors++; if (dones != 1) begin miscompares++; $display("[TB] FAIL single_dones: got %0d expected 1", dones); end
    vectors++; if (fv != 1) begin miscompares++; $display("[TB] FAIL single_latency: got first valid at %0d expected 1", fv); end
    vectors++; if (lv - fv + 1 != 12) begin miscompares++; $display("[TB] FAIL single_contiguous: got span %0d expected 12", lv - fv + 1); end
    vectors++; if (bad !== 1'b0) begin miscompares++; $display("[TB] FAIL single_busy_at_done: got %b expected 0", bad); end
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      vectors++;
      if (obs_q.size() == 0) begin
        miscompares++; $display("[TB] FAIL single_beat%0d: got none expected (%0d,%0d)", i, e.re, e.im);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin miscompares++; $display("[TB] FAIL single_beat%0d: got (%0d,%0d) expected (%0d,%0d)", i, o.re, o.im, e.re, e.im); end
      end
    end
    vectors++; if (sbuf[11] !== wtab[0]) begin miscompares++; $display("[TB] FAIL buffer_slot11: got (%0d,%0d) expected (16384,0)", sbuf[11].re, sbuf[11].im); end
    vectors++; if (sbuf[0] !== wtab[3]) begin miscompares++; $display("[TB] FAIL buffer_slot0: got (%0d,%0d) expected (-11585,-11585)", sbuf[0].re, sbuf[0].im); end
    @(negedge clk);
    vectors++; if (bus3.done !== 1'b0 || bus3.dout_weight_valid !== 1'b0) begin
      miscompares++; $display("[TB] FAIL single_after_done: got done %b valid %b expected 0 0", bus3.done, bus3.dout_weight_valid);
    end
    vectors++; if (bus3.dout_weight_real !== -16'sd11585 || bus3.dout_weight_imag !== -16'sd11585) begin
      miscompares++; $display("[TB] FAIL single_hold: got (%0d,%0d) expected (-11585,-11585)", bus3.dout_weight_real, bus3.dout_weight_imag);
    end
  endtask

  task automatic test_start_ignored();
    int beats, dones, fv, lv, n;
    logic bad, bd;
    bit to;
    w16_t e, o;
    obs_q.delete();
    push_stream3();
    pulse_start3();
    capture3(40, 1, beats, dones, fv, lv, bd, to);
    vectors++; if (to || beats != 12 || dones != 1 || fv != 1) begin
      miscompares++; $display("[TB] FAIL ignore_stream: got beats %0d dones %0d first %0d timeout %0d expected 12 1 1 0", beats, dones, fv, to);
    end
    @(negedge clk);
    bus3.start = 1'b0;
    bad = 1'b0;
    repeat (6) begin
      if (bus3.dout_weight_valid !== 1'b0 || bus3.busy !== 1'b0) bad = 1'b1;
      @(negedge clk);
    end
    vectors++; if (bad !== 1'b0) begin miscompares++; $display("[TB] FAIL ignore_restart: got activity %b expected 0", bad); end
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      vectors++;
      if (obs_q.size() == 0) begin
        miscompares++; $display("[TB] FAIL ignore_beat%0d: got none expected (%0d,%0d)", i, e.re, e.im);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin miscompares++; $display("[TB] FAIL ignore_beat%0d: got (%0d,%0d) expected (%0d,%0d)", i, o.re, o.im, e.re, e.im); end
      end
    end
  endtask

  task automatic test_back_to_back();
    int runs, dones, run_len, gap_len;
    logic prev_v;
    w16_t e, o;
    exp_q.delete();
    // Start held for 40 cycles yields three complete streams.
    repeat (3) push_stream3();
    runs = 0; dones = 0; run_len = 0; gap_len = 0; prev_v = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (bus3.dout_weight_valid === 1'b1) begin
        if (!prev_v && runs > 0) begin
          vectors++; if (gap_len < 2) begin miscompares++; $display("[TB] FAIL b2b_gap: got %0d expected at least 2", gap_len); end
        end
        run_len++;
        o.re = bus3.dout_weight_real;
        o.im = bus3.dout_weight_imag;
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++; $display("[TB] FAIL b2b_extra_beat: got (%0d,%0d) expected no beat", o.re, o.im);
        end else begin
          e = exp_q.pop_front();
          if (o !== e) begin miscompares++; $display("[TB] FAIL b2b_beat: got (%0d,%0d) expected (%0d,%0d)", o.re, o.im, e.re, e.im); end
        end
      end else begin
        if (prev_v) begin
          runs++;
          vectors++; if (run_len != 12) begin miscompares++; $display("[TB] FAIL b2b_run_len: got %0d expected 12", run_len); end
          run_len = 0;
          gap_len = 0;
        end
        gap_len++;
      end
      if (bus3.done === 1'b1) begin
        dones++;
        vectors++; if (bus3.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_busy_at_done: got %b expected 0", bus3.busy); end
      end
      prev_v = bus3.dout_weight_valid;
      bus3.start = (c < 40);
      @(negedge clk);
    end
    bus3.start = 1'b0;
    vectors++; if (runs != 3) begin miscompares++; $display("[TB] FAIL b2b_runs: got %0d expected 3", runs); end
    vectors++; if (dones != 3) begin miscompares++; $display("[TB] FAIL b2b_dones: got %0d expected 3", dones); end
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("[TB] FAIL b2b_leftover: got %0d expected 0", exp_q.size()); end
  endtask

  task automatic test_reset_abort();
    int beats, dones, fv, lv, n;
    logic bad, bd;
    bit to;
    w16_t e, o;
    exp_q.delete();
    obs_q.delete();
    push_stream3();
    pulse_start3();
    beats = 0;
    for (int c = 0; c < 30; c++) begin
      if (bus3.dout_weight_valid === 1'b1) begin
        o.re = bus3.dout_weight_real;
        o.im = bus3.dout_weight_imag;
        e = exp_q.pop_front();
        vectors++; if (o !== e) begin miscompares++; $display("[TB] FAIL abort_beat%0d: got (%0d,%0d) expected (%0d,%0d)", beats, o.re, o.im, e.re, e.im); end
        beats++;
        if (beats == 5) break;
      end
      @(negedge clk);
    end
    vectors++; if (beats != 5) begin miscompares++; $display("[TB] FAIL abort_reach5: got %0d beats expected 5", beats); end
    rst_n = 1'b0;
    #1;
    vectors++; if (bus3.dout_weight_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_valid: got %b expected 0", bus3.dout_weight_valid); end
    vectors++; if (bus3.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_busy: got %b expected 0", bus3.busy); end
    vectors++; if (bus3.dout_weight_real !== 16'sd0 || bus3.dout_weight_imag !== 16'sd0) begin
      miscompares++; $display("[TB] FAIL abort_weight: got (%0d,%0d) expected (0,0)", bus3.dout_weight_real, bus3.dout_weight_imag);
    end
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bad = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus3.done !== 1'b0 || bus3.dout_weight_valid !== 1'b0 || bus3.busy !== 1'b0) bad = 1'b1;
    end
    vectors++; if (bad !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_no_done: got activity %b expected 0", bad); end
    obs_q.delete();
    push_stream3();
    pulse_start3();
    capture3(40, 0, beats, dones, fv, lv, bd, to);
    vectors++; if (to || beats != 12 || dones != 1) begin
      miscompares++; $display("[TB] FAIL replay_stream: got beats %0d dones %0d timeout %0d expected 12 1 0", beats, dones, to);
    end
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      vectors++;
      if (obs_q.size() == 0) begin
        miscompares++; $display("[TB] FAIL replay_beat%0d: got none expected (%0d,%0d)", i, e.re, e.im);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin miscompares++; $display("[TB] FAIL replay_beat%0d: got (%0d,%0d) expected (%0d,%0d)", i, o.re, o.im, e.re, e.im); end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_npoint4();
    int beats, dones;
    w12_t e;
    beats = 0; dones = 0;
    bus4.start = 1'b1;
    @(negedge clk);
    bus4.start = 1'b0;
    for (int c = 0; c < 80; c++) begin
      if (bus4.dout_weight_valid === 1'b1) begin
        if (beats < 32) begin
          obs4[beats].re = bus4.dout_weight_real;
          obs4[beats].im = bus4.dout_weight_imag;
        end
        beats++;
      end
      if (bus4.done === 1'b1) begin
        dones++;
        break;
      end
      @(negedge clk);
    end
    vectors++; if (beats != 32) begin miscompares++; $display("[TB] FAIL n4_beats: got %0d expected 32", beats); end
    vectors++; if (dones != 1) begin miscompares++; $display("[TB] FAIL n4_done: got %0d expected 1", dones); end
    e = '{re: 12'sd1024, im: 12'sd0};
    vectors++; if (obs4[0] !== e) begin miscompares++; $display("[TB] FAIL n4_p0: got (%0d,%0d) expected (1024,0)", obs4[0].re, obs4[0].im); end
    e = '{re: 12'sd946, im: -12'sd392};
    vectors++; if (obs4[25] !== e) begin miscompares++; $display("[TB] FAIL n4_p25: got (%0d,%0d) expected (946,-392)", obs4[25].re, obs4[25].im); end
    e = '{re: 12'sd0, im: -12'sd1024};
    vectors++; if (obs4[28] !== e) begin miscompares++; $display("[TB] FAIL n4_p28: got (%0d,%0d) expected (0,-1024)", obs4[28].re, obs4[28].im); end
    e = '{re: -12'sd946, im: -12'sd392};
    vectors++; if (obs4[31] !== e) begin miscompares++; $display("[TB] FAIL n4_p31: got (%0d,%0d) expected (-946,-392)", obs4[31].re, obs4[31].im); end
  endtask

  initial begin
    bus3.start = 1'b0;
    bus4.start = 1'b0;
    wtab[0] = '{re: 16'sd16384,  im: 16'sd0};
    wtab[1] = '{re: 16'sd11585,  im: -16'sd11585};
    wtab[2] = '{re: 16'sd0,      im: -16'sd16384};
    wtab[3] = '{re: -16'sd11585, im: -16'sd11585};
    kseq    = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};
    for (int i = 0; i < 12; i++) sbuf[i] = '0;
    $display("[TB] starting twiddle_loader bench");
    test_reset();
    test_single_stream();
    test_start_ignored();
    test_back_to_back();
    test_reset_abort();
    test_npoint4();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no completion expected finish before 500000 time units");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
